// File: rtl/dm_cache_ctrl_pkg.sv
// rtl/dm_cache_ctrl_pkg.sv - cache_definition package: cache geometry, array and bus types, FSM states
package cache_definition;

    localparam int TAG_MSB = 19;
    localparam int TAG_LSB = 14;
    localparam int IDX_MSB = 13;
    localparam int IDX_LSB = 4;
    localparam int TAG_W   = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_table_type;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             we;
    } cache_index_type;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic [19:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_to_cache_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
        logic        stopped;
    } cache_to_cpu_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_to_cache_type;

    typedef struct packed {
        logic [19:0]    addr;
        cache_data_type data;
        logic           rw;
        logic           valid;
    } cache_to_mem_type;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } cache_state_type;

    function automatic logic [31:0] get_word(input cache_data_type line, input logic [1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// rtl/dm_cache_array.sv - 1024-line tag/data arrays, combinational read, synchronous write
module dm_cache_array
    import cache_definition::*;
(
    input  logic            clk,
    input  logic            rst,
    input  cache_index_type tag_req,
    input  cache_table_type tag_wdata,
    output cache_table_type tag_rdata,
    input  cache_index_type data_req,
    input  cache_data_type  data_wdata,
    output cache_data_type  data_rdata
);

    logic [1023:0]    valid_q;
    logic [1023:0]    dirty_q;
    logic [TAG_W-1:0] tag_mem  [1024];
    cache_data_type   data_mem [1024];

    assign tag_rdata.valid = valid_q[tag_req.index];
    assign tag_rdata.dirty = dirty_q[tag_req.index];
    assign tag_rdata.tag   = tag_mem[tag_req.index];
    assign data_rdata      = data_mem[data_req.index];

    // Status bits: reset invalidates every line and drops dirty data
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (tag_req.we) begin
            valid_q[tag_req.index] <= tag_wdata.valid;
            dirty_q[tag_req.index] <= tag_wdata.dirty;
        end
    end

    // Tag storage needs no reset; it is meaningless while the line is invalid
    always_ff @(posedge clk) begin
        if (tag_req.we) begin
            tag_mem[tag_req.index] <= tag_wdata.tag;
        end
    end

    // Line data storage
    always_ff @(posedge clk) begin
        if (data_req.we) begin
            data_mem[data_req.index] <= data_wdata;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - write-back/write-allocate direct-mapped cache FSM; optional DM_CACHE_STATS_EN counters
module dm_cache_ctrl
    import cache_definition::*;
(
    input  logic             clk,
    input  logic             rst,
    input  cpu_to_cache_type cpu_req,
    input  mem_to_cache_type mem_res,
    output cache_to_cpu_type cpu_res,
    output cache_to_mem_type mem_req
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    cache_state_type  state;
    cache_state_type  next_state;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       wsel;
    logic             hit;
    cache_table_type  tag_rdata;
    cache_table_type  tag_wdata;
    cache_index_type  tag_req;
    cache_data_type   data_rdata;
    cache_data_type   data_wdata;
    cache_index_type  data_req;
    logic             unused_addr_bits;

    assign tag  = cpu_req.addr[TAG_MSB:TAG_LSB];
    assign idx  = cpu_req.addr[IDX_MSB:IDX_LSB];
    assign wsel = cpu_req.addr[3:2];
    assign hit  = tag_rdata.valid && (tag_rdata.tag == tag);
    assign unused_addr_bits = &{1'b0, cpu_req.addr[1:0]};

    dm_cache_array u_array (
        .clk        (clk),
        .rst        (rst),
        .tag_req    (tag_req),
        .tag_wdata  (tag_wdata),
        .tag_rdata  (tag_rdata),
        .data_req   (data_req),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata)
    );

    // State register; reset wins over any pending transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, CPU/memory outputs and array write requests
    always_comb begin
        next_state     = state;
        cpu_res        = '0;
        mem_req        = '0;
        tag_req.index  = idx;
        tag_req.we     = 1'b0;
        data_req.index = idx;
        data_req.we    = 1'b0;
        tag_wdata      = tag_rdata;
        data_wdata     = data_rdata;
        case (state)
            IDLE: begin
                if (cpu_req.valid) begin
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_res.ready = 1'b1;
                    cpu_res.data  = get_word(data_rdata, wsel);
                    if (cpu_req.rw) begin
                        data_wdata[{wsel, 5'b0} +: 32] = cpu_req.data;
                        data_req.we     = 1'b1;
                        tag_wdata.dirty = 1'b1;
                        tag_req.we      = 1'b1;
                    end
                    next_state = IDLE;
                end else if (tag_rdata.valid && tag_rdata.dirty) begin
                    next_state = WRITE_BACK;
                end else begin
                    next_state = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                cpu_res.stopped = 1'b1;
                mem_req.addr    = {tag_rdata.tag, idx, 4'h0};
                mem_req.data    = data_rdata;
                mem_req.rw      = 1'b1;
                mem_req.valid   = 1'b1;
                if (mem_res.ready) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_res.stopped = 1'b1;
                mem_req.addr    = {tag, idx, 4'h0};
                mem_req.valid   = 1'b1;
                if (mem_res.ready) begin
                    data_wdata  = mem_res.data;
                    data_req.we = 1'b1;
                    tag_wdata   = '{valid: 1'b1, dirty: 1'b0, tag: tag};
                    tag_req.we  = 1'b1;
                    next_state  = COMPARE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef DM_CACHE_STATS_EN
    logic first_cmp;

    // Count only the COMPARE entered from IDLE, never the post-refill one
    always_ff @(posedge clk) begin
        if (rst) begin
            first_cmp <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            first_cmp <= (state == IDLE);
            if (state == COMPARE && first_cmp) begin
                if (hit) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`else
    // Statistics counters not built
`endif

endmodule
